fb_write_arbiter: RTL and testbench

//  Single-port write controller for the dual-port VGA frame buffer (AWxDW RAM).

---
 rtl/fb_write_arbiter_pkg.sv | 16 +
 rtl/fb_write_arbiter_rr_arb2.sv | 25 ++
 rtl/fb_write_arbiter.sv | 113 +++++++++++
 tb/tb_fb_write_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fb_write_arbiter_pkg.sv
// fb_pkg: shared defaults and state encoding for the frame-buffer write arbiter.
//   FB_AW / FB_DW   default address / pixel widths (32K pixels, RGB111)
//   FB_CLEAR_COLOR  default colour written by the clear sweep
//   fb_state_t      controller state (ST_RUN, ST_CLEAR)
package fb_pkg;

  localparam int unsigned FB_AW = 15;
  localparam int unsigned FB_DW = 3;
  localparam logic [2:0]  FB_CLEAR_COLOR = 3'b000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_t;

endpackage

// File: rtl/fb_write_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant.
//   req[1:0]  request per port
//   last      port granted most recently (a tie goes to the other port)
//   en        grant enable; no grant when low
//   gnt[1:0]  one-hot grant (or zero)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: single write port controller for the VGA frame buffer.
// Two requesters share the RAM write port through a round-robin arbiter;
// a clear sweep can fill the whole buffer with CLEAR_COLOR.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   clear_req                  1-cycle pulse starting a clear sweep
//   valid0/addr0/data0/ready0  requester 0 handshake
//   valid1/addr1/data1/ready1  requester 1 handshake
//   mem_we/mem_addr/mem_data   registered RAM write port
//   busy                       high while the clear sweep runs
// Build option: define CLEAR_ON_RESET_EN to run a full clear sweep after reset.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned    AW          = FB_AW,
  parameter int unsigned    DW          = FB_DW,
  parameter logic [DW-1:0]  CLEAR_COLOR = DW'(FB_CLEAR_COLOR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  input  logic          valid0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] data0,
  output logic          ready0,
  input  logic          valid1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] data1,
  output logic          ready1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          busy
);

`ifdef CLEAR_ON_RESET_EN
  localparam fb_state_t RESET_STATE = ST_CLEAR;
`else
  localparam fb_state_t RESET_STATE = ST_RUN;
`endif

  localparam logic [AW-1:0] LAST_ADDR = '1;

  fb_state_t     state, state_nx;
  logic [AW-1:0] clr_cnt;
  logic          last_grant;
  logic          arb_en;
  logic [1:0]    gnt;
  logic          sweep_done;
  logic          clr_write;

  rr_arb2 u_arb (
    .req  ({valid1, valid0}),
    .last (last_grant),
    .en   (arb_en),
    .gnt  (gnt)
  );

  assign ready0 = gnt[0];
  assign ready1 = gnt[1];
  assign busy   = (state == ST_CLEAR);

  // The sweep ends once the final address is already on the write port;
  // mem_we distinguishes this from the idle post-reset outputs.
  assign sweep_done = (state == ST_CLEAR) && mem_we && (mem_addr == LAST_ADDR);

  // Entry into CLEAR issues address 0 on the same edge, so the sweep's
  // writes occupy exactly the cycles in which busy is high.
  assign clr_write = ((state == ST_RUN) && clear_req) ||
                     ((state == ST_CLEAR) && !sweep_done);

  always_comb begin
    state_nx = state;
    arb_en   = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (clear_req) state_nx = ST_CLEAR;
        else           arb_en   = 1'b1;
      end
      ST_CLEAR: begin
        if (sweep_done) state_nx = ST_RUN;
      end
      default: state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RESET_STATE;
      clr_cnt    <= '0;
      last_grant <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      state <= state_nx;
      if (clr_write) begin
        mem_we   <= 1'b1;
        mem_addr <= clr_cnt;
        mem_data <= CLEAR_COLOR;
        clr_cnt  <= clr_cnt + AW'(1);
      end else if (|gnt) begin
        mem_we     <= 1'b1;
        mem_addr   <= gnt[1] ? addr1 : addr0;
        mem_data   <= gnt[1] ? data1 : data0;
        last_grant <= gnt[1];
      end else begin
        mem_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter (AW=4, 16 pixels, default build).
module tb_fb_write_arbiter;

  localparam logic [2:0] CC = 3'b110;

  logic       clk = 1'b0;
  logic       reset, clear_req;
  logic       valid0, valid1, ready0, ready1;
  logic [3:0] addr0, addr1, mem_addr;
  logic [2:0] data0, data1, mem_data;
  logic       mem_we, busy;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Behavioural model: expected registered write, clear-sweep flag, last port.
  logic       m_clear, m_we, m_last, m_post_reset;
  logic [3:0] m_addr;
  logic [2:0] m_data;
  logic       m_g0, m_g1;
  logic       dut_r0, dut_r1;

  fb_write_arbiter #(.AW(4), .DW(3), .CLEAR_COLOR(CC)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .valid0(valid0), .addr0(addr0), .data0(data0), .ready0(ready0),
    .valid1(valid1), .addr1(addr1), .data1(data1), .ready1(ready1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare at +1, advance the model, wait an edge.
  task automatic step(input logic r, input logic cr,
                      input logic v0, input logic [3:0] a0, input logic [2:0] d0,
                      input logic v1, input logic [3:0] a1, input logic [2:0] d1);
    reset = r; clear_req = cr;
    valid0 = v0; addr0 = a0; data0 = d0;
    valid1 = v1; addr1 = a1; data1 = d1;
    #1;
    chk("mem_we", 32'(mem_we), 32'(m_we));
    if (m_we || m_post_reset) begin
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_data", 32'(mem_data), 32'(m_data));
    end
    chk("busy", 32'(busy), 32'(m_clear));
    m_g0 = 1'b0; m_g1 = 1'b0;
    if (!m_clear && !cr) begin
      if (v0 && v1) begin
        m_g0 = m_last;      // port 1 was last -> port 0 wins
        m_g1 = !m_last;
      end else begin
        m_g0 = v0;
        m_g1 = v1;
      end
    end
    chk("ready0", 32'(ready0), 32'(m_g0));
    chk("ready1", 32'(ready1), 32'(m_g1));
    dut_r0 = ready0; dut_r1 = ready1;
    m_post_reset = 1'b0;
    if (r) begin
      m_clear = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0; m_last = 1'b1;
      m_post_reset = 1'b1;
    end else if (m_clear) begin
      if (m_addr == 4'd15) begin
        m_clear = 1'b0; m_we = 1'b0;
      end else begin
        m_addr = m_addr + 4'd1;
      end
    end else if (cr) begin
      m_clear = 1'b1; m_we = 1'b1; m_addr = '0; m_data = CC;
    end else if (m_g0) begin
      m_we = 1'b1; m_addr = a0; m_data = d0; m_last = 1'b0;
    end else if (m_g1) begin
      m_we = 1'b1; m_addr = a1; m_data = d1; m_last = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 4'd0, 3'd0);
  endtask

  initial begin
    int unsigned cnt;
    logic [3:0]  pat;
    logic        saw12;
    logic        p0, p1;
    logic [3:0]  pa0, pa1;
    logic [2:0]  pd0, pd1;

    reset = 1'b1; clear_req = 1'b0;
    valid0 = 1'b0; addr0 = '0; data0 = '0;
    valid1 = 1'b0; addr1 = '0; data1 = '0;
    m_clear = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0; m_last = 1'b1;
    m_post_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Single requester, latency 1
    step(1'b0, 1'b0, 1'b1, 4'd5, 3'b101, 1'b0, 4'd0, 3'd0);
    chk("t1_ready0", 32'(dut_r0), 32'd1);
    chk("t1_we", 32'(mem_we), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'd5);
    chk("t1_data", 32'(mem_data), 32'd5);

    // Both valid after reset: 0,1,0,1 back to back
    step(1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 4'd0, 3'd0);
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'd2, 3'd1, 1'b1, 4'd9, 3'd6);
      pat[i] = dut_r0;
    end
    chk("t2_pattern", 32'(pat), 32'h5);
    chk("t2_last_addr", 32'(mem_addr), 32'd9);

    // Clear overrides a pending valid1; full 16-write sweep
    step(1'b0, 1'b1, 1'b0, 4'd0, 3'd0, 1'b1, 4'd3, 3'd1);
    chk("t3_ready1_blocked", 32'(dut_r1), 32'd0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (mem_we && busy && mem_addr == 4'(i) && mem_data == CC) cnt++;
      step(1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b1, 4'd3, 3'd1);
    end
    chk("t3_writes", cnt, 32'd16);
    step(1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b1, 4'd3, 3'd1);
    chk("t3_ready1_after", 32'(dut_r1), 32'd1);

    // clear_req during the sweep is ignored
    step(1'b0, 1'b1, 1'b0, 4'd0, 3'd0, 1'b0, 4'd0, 3'd0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (mem_we && busy && mem_addr == 4'(i)) cnt++;
      step(1'b0, (i == 7), 1'b0, 4'd0, 3'd0, 1'b0, 4'd0, 3'd0);
    end
    chk("t4_writes", cnt, 32'd16);
    chk("t4_we_after", 32'(mem_we), 32'd0);
    chk("t4_busy_after", 32'(busy), 32'd0);

    // Reset mid-sweep aborts it
    step(1'b0, 1'b1, 1'b0, 4'd0, 3'd0, 1'b0, 4'd0, 3'd0);
    for (int i = 0; i < 9; i++) idle();
    chk("t5_addr9", 32'(mem_addr), 32'd9);
    step(1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 4'd0, 3'd0);
    chk("t5_we_reset", 32'(mem_we), 32'd0);
    chk("t5_busy_reset", 32'(busy), 32'd0);
    step(1'b0, 1'b0, 1'b1, 4'd3, 3'd2, 1'b0, 4'd0, 3'd0);
    chk("t5_ready0", 32'(dut_r0), 32'd1);

    // valid1 withdrawn before being granted
    step(1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 4'd0, 3'd0);
    saw12 = 1'b0;
    step(1'b0, 1'b0, 1'b1, 4'd4, 3'd1, 1'b1, 4'd12, 3'd7);
    chk("t6_r1_a", 32'(dut_r1), 32'd0);
    if (mem_we && mem_addr == 4'd12) saw12 = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'd6, 3'd2, 1'b0, 4'd0, 3'd0);
    chk("t6_r0_b", 32'(dut_r0), 32'd1);
    if (mem_we && mem_addr == 4'd12) saw12 = 1'b1;
    idle();
    if (mem_we && mem_addr == 4'd12) saw12 = 1'b1;
    chk("t6_no_addr1", 32'(saw12), 32'd0);

    // Randomized traffic honouring the hold-until-ready rule
    p0 = 1'b0; p1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int c = 0; c < 1500; c++) begin
      if (p0 && $urandom_range(0, 7) == 0) p0 = 1'b0;
      else if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1; pa0 = 4'($urandom); pd0 = 3'($urandom);
      end
      if (p1 && $urandom_range(0, 7) == 0) p1 = 1'b0;
      else if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1; pa1 = 4'($urandom); pd1 = 3'($urandom);
      end
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           p0, pa0, pd0, p1, pa1, pd1);
      if (m_g0) p0 = 1'b0;
      if (m_g1) p1 = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
